vu_meter_ctrl: RTL and testbench
================================

Name: vu_meter_ctrl

Overview:
- Sequences the shared 2048-sample volume averager for the stereo VU display.
- Takes the codec's stereo sample stream and feeds exactly one window of samples per measurement from the selected channel.
- Collects each window's averaged volume (0..100) and maintains per-channel level and peak-hold values with timed decay.
- Sits between the codec receive path and the averager; its outputs drive the LED/seven-segment meter.

Parameters:
- WIN, 2048: samples per averaging window; must equal the averager's NUM.
- HOLD_WIN, 4: windows a new peak is held before decay starts.
- DECAY, 5: peak decrement per window once hold expires.
- TIMEOUT, 64: cycles allowed after the last fed sample for the averager to report.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  pulse: begin measuring; clears o_err
- i_stop  in  1  pulse: stop after the current window completes
- i_cont  in  1  1 = continuous windows, 0 = single window then idle
- i_chan_sel  in  2  0 = left, 1 = right, 2 = alternate L/R per window, 3 = reserved (treated as left)
- i_smp_valid  in  1  one-cycle strobe, left and right samples valid together
- i_smp_l  in  16  signed left sample
- i_smp_r  in  16  signed right sample
- o_avg_valid  out  1  sample strobe to averager in_valid
- o_avg_data  out  16  signed sample to averager in_data
- i_avg_done  in  1  averager o_valid pulse
- i_avg_vol  in  8  averager avg_volumn
- o_level_l, o_level_r  out  8 each  last window result per channel
- o_peak_l, o_peak_r  out  8 each  peak-hold value per channel
- o_update  out  1  one-cycle pulse when levels/peaks change
- o_busy  out  1  high in any state other than IDLE
- o_err  out  1  sticky averager-timeout flag

Behaviour:
- Reset: state IDLE. All outputs are 0. Sample counter, hold counters, stop_pending and the alternate-channel toggle (starts at left) are 0.
- IDLE:
  - On i_start: go to FEED, clear o_err, clear the counter, latch the channel for this window.
  - Otherwise samples are ignored and o_avg_valid stays 0.
- FEED:
  - Each i_smp_valid registers the selected sample onto o_avg_data, with o_avg_valid high one cycle later (latency 1). The counter increments.
  - After the WIN-th forwarded sample: go to WAIT and clear the timeout counter.
  - Never forward more or fewer than WIN samples per window, because the averager has no abort.
- WAIT:
  - Incoming samples are dropped.
  - On i_avg_done: capture i_avg_vol into the latched channel's level and go to UPDATE.
  - If TIMEOUT cycles elapse without i_avg_done: set o_err and go to IDLE. Levels are unchanged and there is no o_update.
  - i_avg_done received in any state other than WAIT is ignored.
- UPDATE (1 cycle):
  - Peak for the measured channel:
    - if level >= peak: peak = level and reload hold = HOLD_WIN;
    - else if hold > 0: hold decrements;
    - else peak = max(peak - DECAY, level), saturating and never dropping below level.
  - The unmeasured channel's peak is untouched.
  - Pulse o_update.
  - Next state: if stop_pending or !i_cont, go to IDLE and clear stop_pending. Otherwise go to FEED, toggling the channel when i_chan_sel == 2.
- i_stop in FEED/WAIT/UPDATE sets stop_pending; the current window always completes. i_stop in IDLE has no effect.
- i_start while busy is ignored.
- i_chan_sel changes take effect only at the next window start.
- Simultaneous i_start and i_stop in IDLE: start wins and stop_pending is set, so exactly one window runs.
- Arithmetic: all levels are 8-bit unsigned in 0..100. The counter is clog2(WIN)+1 bits wide.
- Reset mid-window: immediate return to IDLE. The averager must be reset by the same i_rst_n.

Decomposition:
- Package vu_pkg holds:
  - the state enum (S_IDLE, S_FEED, S_WAIT, S_UPDATE);
  - the channel-select constants CH_L, CH_R, CH_ALT;
  - the constant VOL_MAX = 100.
- Sub-module vu_peak_hold (one instance per channel) holds the level/peak/hold registers and the decay update, enabled by an update strobe and a channel match.

Test Plan:
- Single window, left: i_cont=0, sel=0, 2048 samples of +0x1000, model returns 80 → exactly 2048 o_avg_valid pulses carrying 0x1000; o_level_l=80, o_peak_l=80, one o_update, then IDLE with o_busy=0.
- Alternate continuous: sel=2; model returns 60 then 30 → o_level_l=60 then o_level_r=30; channels alternate L,R,L; o_peak_r=30.
- Peak decay: left levels 90, then 20 for 6 windows → peak holds at 90 for 4 windows, then 85, then 80.
- Deferred stop: i_stop at sample 1000 → the remaining 1048 samples are still fed, the result is captured, then IDLE; no further o_avg_valid.
- Timeout: model never asserts done → o_err=1 at 64 cycles after the last sample, state IDLE, levels unchanged; the next i_start clears o_err.
- Samples arriving in WAIT or IDLE → o_avg_valid stays 0; the next window's count still equals exactly 2048.

Source files
------------

// File: rtl/vu_pkg.sv
// Shared types, constants and small arithmetic helpers for the VU meter sequencer.
package vu_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FEED   = 2'd1,
      S_WAIT   = 2'd2,
      S_UPDATE = 2'd3
   } state_t;

   localparam logic [1:0] CH_L    = 2'd0;
   localparam logic [1:0] CH_R    = 2'd1;
   localparam logic [1:0] CH_ALT  = 2'd2;
   localparam logic [7:0] VOL_MAX = 8'd100;

   // Channel measured by a window starting now: 0 = left, 1 = right; the reserved code reads as left.
   function automatic logic chan_of(input logic [1:0] sel, input logic alt);
      logic ch;
      case (sel)
         CH_L:    ch = 1'b0;
         CH_R:    ch = 1'b1;
         CH_ALT:  ch = alt;
         default: ch = 1'b0;
      endcase
      return ch;
   endfunction

   function automatic logic [7:0] clamp_vol(input logic [7:0] v);
      return (v > VOL_MAX) ? VOL_MAX : v;
   endfunction

   function automatic logic [7:0] decay_peak(input logic [7:0] peak,
                                             input logic [7:0] level,
                                             input logic [7:0] dec);
      logic [7:0] p;
      p = (peak > dec) ? (peak - dec) : 8'd0;
      return (p > level) ? p : level;
   endfunction

endpackage

// File: rtl/vu_peak_hold.sv
// Per-channel level register plus peak-hold with timed decay.
module vu_peak_hold
   import vu_pkg::*;
#(
   parameter int HOLD_WIN = 4,
   parameter int DECAY    = 5
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_cap,
   input  logic [7:0] i_vol,
   input  logic       i_upd,
   output logic [7:0] o_level,
   output logic [7:0] o_peak
);

   localparam int            HW        = $clog2(HOLD_WIN + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_WIN);
   localparam logic [7:0]    DEC       = 8'(DECAY);

   logic [7:0]    level_q, level_d;
   logic [7:0]    peak_q, peak_d;
   logic [HW-1:0] hold_q, hold_d;

   // A new level is captured when the averager reports; the peak reacts one cycle later.
   always_comb begin
      level_d = level_q;
      peak_d  = peak_q;
      hold_d  = hold_q;
      if (i_cap) begin
         level_d = clamp_vol(i_vol);
      end else begin
         level_d = level_q;
      end
      if (i_upd) begin
         if (level_q >= peak_q) begin
            peak_d = level_q;
            hold_d = HOLD_LOAD;
         end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
         end else begin
            peak_d = decay_peak(peak_q, level_q, DEC);
         end
      end else begin
         peak_d = peak_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         level_q <= 8'd0;
         peak_q  <= 8'd0;
         hold_q  <= '0;
      end else begin
         level_q <= level_d;
         peak_q  <= peak_d;
         hold_q  <= hold_d;
      end
   end

   assign o_level = level_q;
   assign o_peak  = peak_q;

endmodule

// File: rtl/vu_meter_ctrl.sv
// Feeds exactly one averager window per measurement from the selected channel
// and turns each result into per-channel level and peak-hold values.
module vu_meter_ctrl
   import vu_pkg::*;
#(
   parameter int WIN      = 2048,
   parameter int HOLD_WIN = 4,
   parameter int DECAY    = 5,
   parameter int TIMEOUT  = 64
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic        i_cont,
   input  logic [1:0]  i_chan_sel,
   input  logic        i_smp_valid,
   input  logic [15:0] i_smp_l,
   input  logic [15:0] i_smp_r,
   output logic        o_avg_valid,
   output logic [15:0] o_avg_data,
   input  logic        i_avg_done,
   input  logic [7:0]  i_avg_vol,
   output logic [7:0]  o_level_l,
   output logic [7:0]  o_level_r,
   output logic [7:0]  o_peak_l,
   output logic [7:0]  o_peak_r,
   output logic        o_update,
   output logic        o_busy,
   output logic        o_err
);

   localparam int            CW       = $clog2(WIN) + 1;
   localparam int            TW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIN - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          ch_q, ch_d;
   logic          alt_q, alt_d;
   logic          stop_q, stop_d;
   logic          err_q, err_d;
   logic          avg_valid_q, avg_valid_d;
   logic [15:0]   avg_data_q, avg_data_d;
   logic          update_q, update_d;
   logic          busy_q, busy_d;

   logic          last_smp_s;
   logic          tmo_hit_s;
   logic          end_run_s;
   logic          alt_nx_s;
   logic          cap_s;
   logic          upd_s;

   assign last_smp_s = i_smp_valid && (cnt_q == CNT_LAST);
   assign tmo_hit_s  = (tmo_q == TMO_LAST);
   assign end_run_s  = stop_q || i_stop || !i_cont;
   assign alt_nx_s   = (i_chan_sel == CH_ALT) ? ~alt_q : alt_q;
   assign busy_d     = (state_d != S_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The averager cannot abort, so FEED only exits on the last sample of the window.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) state_d = S_FEED;
            else         state_d = S_IDLE;
         end
         S_FEED: begin
            if (last_smp_s) state_d = S_WAIT;
            else            state_d = S_FEED;
         end
         S_WAIT: begin
            if (i_avg_done)     state_d = S_UPDATE;
            else if (tmo_hit_s) state_d = S_IDLE;
            else                state_d = S_WAIT;
         end
         S_UPDATE: begin
            if (end_run_s) state_d = S_IDLE;
            else           state_d = S_FEED;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      ch_d        = ch_q;
      alt_d       = alt_q;
      stop_d      = stop_q;
      err_d       = err_q;
      avg_valid_d = 1'b0;
      avg_data_d  = avg_data_q;
      update_d    = 1'b0;
      cap_s       = 1'b0;
      upd_s       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               err_d  = 1'b0;
               cnt_d  = '0;
               ch_d   = chan_of(i_chan_sel, alt_q);
               stop_d = i_stop;
            end else begin
               stop_d = 1'b0;
            end
         end
         S_FEED: begin
            stop_d = stop_q | i_stop;
            if (i_smp_valid) begin
               avg_valid_d = 1'b1;
               avg_data_d  = ch_q ? i_smp_r : i_smp_l;
               cnt_d       = cnt_q + CW'(1);
               tmo_d       = last_smp_s ? '0 : tmo_q;
            end else begin
               avg_valid_d = 1'b0;
            end
         end
         S_WAIT: begin
            stop_d = stop_q | i_stop;
            if (i_avg_done) begin
               cap_s = 1'b1;
            end else if (tmo_hit_s) begin
               err_d  = 1'b1;
               stop_d = 1'b0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_UPDATE: begin
            upd_s    = 1'b1;
            update_d = 1'b1;
            stop_d   = 1'b0;
            if (end_run_s) begin
               cnt_d = cnt_q;
            end else begin
               cnt_d = '0;
               alt_d = alt_nx_s;
               ch_d  = chan_of(i_chan_sel, alt_nx_s);
            end
         end
         default: begin
            stop_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q       <= '0;
         tmo_q       <= '0;
         ch_q        <= 1'b0;
         alt_q       <= 1'b0;
         stop_q      <= 1'b0;
         err_q       <= 1'b0;
         avg_valid_q <= 1'b0;
         avg_data_q  <= 16'd0;
         update_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         ch_q        <= ch_d;
         alt_q       <= alt_d;
         stop_q      <= stop_d;
         err_q       <= err_d;
         avg_valid_q <= avg_valid_d;
         avg_data_q  <= avg_data_d;
         update_q    <= update_d;
         busy_q      <= busy_d;
      end
   end

   vu_peak_hold #(
      .HOLD_WIN (HOLD_WIN),
      .DECAY    (DECAY)
   ) u_peak_l (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_cap   (cap_s & ~ch_q),
      .i_vol   (i_avg_vol),
      .i_upd   (upd_s & ~ch_q),
      .o_level (o_level_l),
      .o_peak  (o_peak_l)
   );

   vu_peak_hold #(
      .HOLD_WIN (HOLD_WIN),
      .DECAY    (DECAY)
   ) u_peak_r (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_cap   (cap_s & ch_q),
      .i_vol   (i_avg_vol),
      .i_upd   (upd_s & ch_q),
      .o_level (o_level_r),
      .o_peak  (o_peak_r)
   );

   assign o_avg_valid = avg_valid_q;
   assign o_avg_data  = avg_data_q;
   assign o_update    = update_q;
   assign o_busy      = busy_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_vu_meter_ctrl.sv
// Randomised bench for vu_meter_ctrl: a window-level reference model plus an averager stand-in.
module tb_vu_meter_ctrl;

   localparam int WIN      = 2048;
   localparam int HOLD_WIN = 4;
   localparam int DECAY    = 5;
   localparam int TIMEOUT  = 64;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0, i_stop = 1'b0, i_cont = 1'b0;
   logic [1:0]  i_chan_sel = 2'd0;
   logic        i_smp_valid = 1'b0;
   logic [15:0] i_smp_l = 16'd0, i_smp_r = 16'd0;
   logic        i_avg_done = 1'b0;
   logic [7:0]  i_avg_vol = 8'd0;
   logic        o_avg_valid, o_update, o_busy, o_err;
   logic [15:0] o_avg_data;
   logic [7:0]  o_level_l, o_level_r, o_peak_l, o_peak_r;

   always #5 i_clk = ~i_clk;

   vu_meter_ctrl dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop), .i_cont(i_cont),
      .i_chan_sel(i_chan_sel), .i_smp_valid(i_smp_valid), .i_smp_l(i_smp_l), .i_smp_r(i_smp_r),
      .o_avg_valid(o_avg_valid), .o_avg_data(o_avg_data), .i_avg_done(i_avg_done),
      .i_avg_vol(i_avg_vol), .o_level_l(o_level_l), .o_level_r(o_level_r),
      .o_peak_l(o_peak_l), .o_peak_r(o_peak_r), .o_update(o_update), .o_busy(o_busy), .o_err(o_err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: measurement phase as plain integers, per-channel results in arrays.
   localparam int P_FEED = 0, P_WAIT = 1, P_UPD = 2;
   int m_busy = 0, m_phase = 0, m_fed = 0, m_wait = 0, m_ch = 0, m_alt = 0;
   int m_stop = 0, m_err = 0, m_win = 0;
   int m_level[2] = '{0, 0};
   int m_peak[2]  = '{0, 0};
   int m_hold[2]  = '{0, 0};
   logic        exp_valid = 1'b0, exp_update = 1'b0;
   logic [15:0] exp_data = 16'd0;

   int vol_q[$];
   int done_at = -1, pend_vol = 0, cyc = 0;
   int stop_win = -1, stop_fed = -1;
   bit fix_left = 1'b0, rand_sel = 1'b0, chk_en = 1'b0;
   int pulse_cnt = 0, upd_cnt = 0;
   int log_pl[$], log_ll[$], log_lr[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [1:0] sel);
      if (sel == 2'd1) return 1;
      if (sel == 2'd2) return m_alt;
      return 0;
   endfunction

   task automatic model_step();
      int lv, dk;
      exp_valid  = 1'b0;
      exp_update = 1'b0;
      if (m_busy == 0) begin
         if (i_start) begin
            m_busy = 1; m_err = 0; m_stop = int'(i_stop);
            m_phase = P_FEED; m_fed = 0; m_win = 0; m_ch = pick(i_chan_sel);
         end
      end else if (m_phase == P_FEED) begin
         if (i_stop) m_stop = 1;
         if (i_smp_valid) begin
            exp_valid = 1'b1;
            exp_data  = (m_ch != 0) ? i_smp_r : i_smp_l;
            m_fed++;
            if (m_fed == WIN) begin
               m_phase = P_WAIT; m_wait = 0;
               if (vol_q.size() > 0) begin
                  pend_vol = vol_q.pop_front();
                  done_at  = cyc + 1 + int'($urandom_range(0, 20));
               end else begin
                  done_at = -1;
               end
            end
         end
      end else if (m_phase == P_WAIT) begin
         if (i_stop) m_stop = 1;
         if (i_avg_done) begin
            m_level[m_ch] = int'(i_avg_vol);
            m_phase = P_UPD;
         end else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
               m_err = 1; m_busy = 0; m_stop = 0;
            end
         end
      end else begin
         lv = m_level[m_ch];
         if (lv >= m_peak[m_ch]) begin
            m_peak[m_ch] = lv; m_hold[m_ch] = HOLD_WIN;
         end else if (m_hold[m_ch] > 0) begin
            m_hold[m_ch]--;
         end else begin
            dk = m_peak[m_ch] - DECAY;
            if (dk < 0) dk = 0;
            m_peak[m_ch] = (dk > lv) ? dk : lv;
         end
         exp_update = 1'b1;
         if (m_stop != 0 || i_stop || !i_cont) begin
            m_busy = 0; m_stop = 0;
         end else begin
            if (i_chan_sel == 2'd2) m_alt ^= 1;
            m_ch = pick(i_chan_sel);
            m_phase = P_FEED; m_fed = 0; m_win++;
         end
      end
   endtask

   // One clock: random samples, averager stand-in, scheduled stop, then advance the model.
   task automatic tick();
      i_smp_valid = ($urandom_range(0, 3) != 0);
      i_smp_l     = fix_left ? 16'h1000 : 16'($urandom);
      i_smp_r     = 16'($urandom);
      i_avg_done  = 1'b0;
      i_avg_vol   = 8'($urandom_range(0, 100));
      if (rand_sel && m_busy != 0) i_chan_sel = 2'($urandom_range(0, 3));
      if (done_at == cyc) begin
         i_avg_done = 1'b1; i_avg_vol = 8'(pend_vol); done_at = -1;
      end else if ((m_busy == 0 || m_phase == P_FEED) && $urandom_range(0, 15) == 0) begin
         i_avg_done = 1'b1;
      end
      if (m_busy != 0 && m_phase == P_FEED && m_win == stop_win && m_fed == stop_fed) begin
         i_stop = 1'b1; stop_win = -1;
      end
      @(posedge i_clk);
      model_step();
      cyc++;
      #1;
      i_start = 1'b0;
      i_stop  = 1'b0;
   endtask

   task automatic run_to_idle(input string nm);
      int n = 0;
      while (m_busy != 0 && n < 30000) begin
         tick();
         n++;
      end
      repeat (4) tick();
      chk({nm, "_idle"}, int'(o_busy), 0);
   endtask

   task automatic begin_run();
      pulse_cnt = 0; upd_cnt = 0;
      log_pl.delete(); log_ll.delete(); log_lr.delete();
      i_start = 1'b1;
      tick();
   endtask

   always @(negedge i_clk) begin
      if (chk_en) begin
         chk("avg_valid", int'(o_avg_valid), int'(exp_valid));
         if (exp_valid) chk("avg_data", int'(o_avg_data), int'(exp_data));
         chk("update", int'(o_update), int'(exp_update));
         chk("busy", int'(o_busy), m_busy);
         chk("err", int'(o_err), m_err);
         chk("level_l", int'(o_level_l), m_level[0]);
         chk("level_r", int'(o_level_r), m_level[1]);
         chk("peak_l", int'(o_peak_l), m_peak[0]);
         chk("peak_r", int'(o_peak_r), m_peak[1]);
         if (o_avg_valid) pulse_cnt++;
         if (o_update) begin
            upd_cnt++;
            log_pl.push_back(int'(o_peak_l));
            log_ll.push_back(int'(o_level_l));
            log_lr.push_back(int'(o_level_r));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_pk[7];
      exp_pk = '{90, 90, 90, 90, 90, 85, 80};
      repeat (3) @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge i_clk);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_avg_valid", int'(o_avg_valid), 0);
      chk("rst_level_l", int'(o_level_l), 0);
      chk("rst_peak_r", int'(o_peak_r), 0);
      chk("rst_err", int'(o_err), 0);

      // Samples and stray done pulses while idle must be ignored.
      pulse_cnt = 0;
      repeat (30) tick();
      chk("idle_pulses", pulse_cnt, 0);

      // Single left window, constant +0x1000.
      i_chan_sel = 2'd0; i_cont = 1'b0; fix_left = 1'b1;
      vol_q.push_back(80);
      begin_run();
      run_to_idle("single");
      fix_left = 1'b0;
      chk("single_pulses", pulse_cnt, WIN);
      chk("single_updates", upd_cnt, 1);
      chk("single_level_l", int'(o_level_l), 80);
      chk("single_peak_l", int'(o_peak_l), 80);

      // Alternating continuous run L,R,L then stop.
      i_chan_sel = 2'd2; i_cont = 1'b1;
      vol_q = '{60, 30, 45};
      stop_win = 2; stop_fed = 10;
      begin_run();
      run_to_idle("alt");
      chk("alt_pulses", pulse_cnt, 3 * WIN);
      chk("alt_updates", log_ll.size(), 3);
      if (log_ll.size() == 3) begin
         chk("alt_w0_level_l", log_ll[0], 60);
         chk("alt_w1_level_r", log_lr[1], 30);
         chk("alt_w2_level_l", log_ll[2], 45);
      end
      chk("alt_peak_r", int'(o_peak_r), 30);

      // Peak hold then decay on the left channel.
      i_chan_sel = 2'd0;
      vol_q = '{90, 20, 20, 20, 20, 20, 20};
      stop_win = 6; stop_fed = 100;
      begin_run();
      run_to_idle("decay");
      chk("decay_updates", log_pl.size(), 7);
      for (int i = 0; i < 7; i++) begin
         if (i < log_pl.size()) chk("decay_peak_l", log_pl[i], exp_pk[i]);
      end

      // Stop mid-window: the window still completes; channel select wiggles after start.
      i_chan_sel = 2'd1; rand_sel = 1'b1;
      vol_q = '{70};
      stop_win = 0; stop_fed = 1000;
      begin_run();
      run_to_idle("stop");
      rand_sel = 1'b0; i_chan_sel = 2'd0;
      repeat (40) tick();
      chk("stop_pulses", pulse_cnt, WIN);
      chk("stop_updates", upd_cnt, 1);
      chk("stop_level_r", int'(o_level_r), 70);

      // Averager never answers.
      i_cont = 1'b0;
      vol_q.delete();
      begin_run();
      run_to_idle("tmo");
      chk("tmo_err", int'(o_err), 1);
      chk("tmo_updates", upd_cnt, 0);
      chk("tmo_level_l", int'(o_level_l), 20);

      // Start and stop together in continuous mode: one window, error cleared.
      i_cont = 1'b1;
      vol_q = '{100};
      i_stop = 1'b1;
      begin_run();
      chk("restart_err_clear", int'(o_err), 0);
      run_to_idle("startstop");
      chk("startstop_pulses", pulse_cnt, WIN);
      chk("startstop_updates", upd_cnt, 1);
      chk("startstop_peak_l", int'(o_peak_l), 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
